// File: rtl/gcd_processor.sv
// ---------------------------------------------------------------------------
// gcd_processor
//
// 8-bit accumulator processor with a built-in 16-instruction program that
// computes the GCD of two operands by repeated subtraction. Operands X and Y
// are keyed in through `in` / `enter`. The result appears on `out` while
// `halt` is high.
//
// Instruction word: IR[7:5] is the opcode and IR[4:0] is the address.
//   000 LOAD   A <= M[a]
//   001 STORE  M[a] <= A
//   010 ADD    A <= A + M[a]
//   011 SUB    A <= A - M[a]            (mod 256)
//   100 INPUT  A <= in                  (waits for enter)
//   101 JZ     PC <= a if A == 0
//   110 JPOS   PC <= a if A != 0 and A[7] == 0
//   111 HALT
//
// Ports
//   clk           in   1  rising-edge clock
//   reset         in   1  asynchronous active-low reset (0 = reset)
//   init          in   1  synchronous program-image load strobe
//   enter         in   1  operand-valid strobe for INPUT
//   in            in   8  operand data
//   out           out  8  accumulator A
//   halt          out  1  high while in HALT
//   DisplayState  out  4  current FSM state code
//
// Build option
//   PROC_ENTER_EDGE_EN : when defined, INPUT accepts only a 0->1 edge of
//                        enter (registered copy of enter, reset to 0).
//                        When undefined, INPUT accepts enter by level.
// ---------------------------------------------------------------------------
module gcd_processor #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MEM_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              enter,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out,
    output logic              halt,
    output logic [3:0]        DisplayState
);

    localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);
    localparam int unsigned PROG_LEN = 16;

    typedef enum logic [3:0] {
        ST_START  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOAD   = 4'd3,
        ST_STORE  = 4'd4,
        ST_ADD    = 4'd5,
        ST_SUB    = 4'd6,
        ST_INPUT  = 4'd7,
        ST_JZ     = 4'd8,
        ST_JPOS   = 4'd9,
        ST_HALT   = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_INPUT = 3'b100,
        OP_JZ    = 3'b101,
        OP_JPOS  = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    // -----------------------------------------------------------------------
    // Built-in program image
    // -----------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] prog_word(input logic [3:0] idx);
        logic [DATA_W-1:0] w;
        case (idx)
            4'd0:    w = {OP_INPUT, 5'd0};
            4'd1:    w = {OP_STORE, 5'd30};
            4'd2:    w = {OP_INPUT, 5'd0};
            4'd3:    w = {OP_STORE, 5'd31};
            4'd4:    w = {OP_LOAD,  5'd30};
            4'd5:    w = {OP_SUB,   5'd31};
            4'd6:    w = {OP_JZ,    5'd14};
            4'd7:    w = {OP_JPOS,  5'd12};
            4'd8:    w = {OP_LOAD,  5'd31};
            4'd9:    w = {OP_SUB,   5'd30};
            4'd10:   w = {OP_STORE, 5'd31};
            4'd11:   w = {OP_JPOS,  5'd4};
            4'd12:   w = {OP_STORE, 5'd30};
            4'd13:   w = {OP_JPOS,  5'd4};
            4'd14:   w = {OP_LOAD,  5'd30};
            default: w = {OP_HALT,  5'd0};
        endcase
        return w;
    endfunction

    // -----------------------------------------------------------------------
    // Architectural state
    // -----------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q,    pc_d;
    logic [DATA_W-1:0]   ir_q,    ir_d;
    logic [DATA_W-1:0]   a_q,     a_d;
    logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    opcode_t             opcode;
    logic [ADDR_W-1:0]   operand_addr;
    logic [DATA_W-1:0]   operand;
    logic                enter_accept;

    assign opcode       = opcode_t'(ir_q[DATA_W-1:DATA_W-3]);
    assign operand_addr = ir_q[ADDR_W-1:0];
    assign operand      = mem_q[operand_addr];

    // -----------------------------------------------------------------------
    // enter qualification
    // -----------------------------------------------------------------------
`ifdef PROC_ENTER_EDGE_EN
    logic enter_dly_q, enter_dly_d;

    always_comb begin
        enter_dly_d = enter;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter_dly_q <= 1'b0;
        end else begin
            enter_dly_q <= enter_dly_d;
        end
    end

    // A level held across two INPUT instructions is consumed only once.
    assign enter_accept = enter & ~enter_dly_q;
`else
    assign enter_accept = enter;
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_START;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START:  state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD:  state_d = ST_LOAD;
                    OP_STORE: state_d = ST_STORE;
                    OP_ADD:   state_d = ST_ADD;
                    OP_SUB:   state_d = ST_SUB;
                    OP_INPUT: state_d = ST_INPUT;
                    OP_JZ:    state_d = ST_JZ;
                    OP_JPOS:  state_d = ST_JPOS;
                    OP_HALT:  state_d = ST_HALT;
                    default:  state_d = ST_HALT;
                endcase
            end
            ST_LOAD,
            ST_STORE,
            ST_ADD,
            ST_SUB,
            ST_JZ,
            ST_JPOS:   state_d = ST_FETCH;
            ST_INPUT:  state_d = enter_accept ? ST_FETCH : ST_INPUT;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_START;
        endcase

        // Program reload restarts execution regardless of current state.
        if (init) begin
            state_d = ST_START;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs and datapath updates
    // -----------------------------------------------------------------------
    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        mem_we    = 1'b0;
        mem_waddr = operand_addr;
        mem_wdata = a_q;

        if (!init) begin
            case (state_q)
                ST_FETCH: begin
                    ir_d = mem_q[pc_q];
                    pc_d = pc_q + 1'b1;   // 5-bit wrap 31 -> 0
                end
                ST_LOAD:  a_d = operand;
                ST_STORE: mem_we = 1'b1;
                ST_ADD:   a_d = a_q + operand;
                ST_SUB:   a_d = a_q - operand;
                ST_INPUT: begin
                    if (enter_accept) begin
                        a_d = in;
                    end
                end
                ST_JZ: begin
                    if (a_q == '0) begin
                        pc_d = operand_addr;
                    end
                end
                ST_JPOS: begin
                    if ((a_q != '0) && !a_q[DATA_W-1]) begin
                        pc_d = operand_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out          = a_q;
    assign halt         = (state_q == ST_HALT);
    assign DisplayState = state_q;

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
            ir_q <= '0;
            a_q  <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            a_q  <= a_d;
        end
    end

    // -----------------------------------------------------------------------
    // Unified program/data RAM. Not touched by reset, so an init strobe
    // issued while reset is asserted still loads the image.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (init) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= (i < PROG_LEN) ? prog_word(i[3:0]) : '0;
            end
        end else if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_gcd_processor.sv
module tb_gcd_processor;

    logic       clk;
    logic       reset;
    logic       init;
    logic       enter;
    logic [7:0] in_data;
    logic [7:0] out_data;
    logic       halt;
    logic [3:0] display_state;

    int n_vec;
    int n_bad;

    localparam logic [3:0] DS_START = 4'd0;
    localparam logic [3:0] DS_INPUT = 4'd7;
    localparam logic [3:0] DS_HALT  = 4'd10;

    gcd_processor #(.DATA_W(8), .MEM_DEPTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .enter        (enter),
        .in           (in_data),
        .out          (out_data),
        .halt         (halt),
        .DisplayState (display_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [8];

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bounded wait for a state code; an expired budget shows up as a miscompare.
    task automatic wait_ds(input logic [3:0] code, input int budget, input string what);
        int n;
        n = 0;
        while (display_state !== code && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(what, int'(display_state), int'(code));
    endtask

    task automatic pulse_enter(input logic [7:0] v);
        in_data = v;
        enter   = 1'b1;
        @(negedge clk);
        enter   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_gcd(input logic [7:0] x, input logic [7:0] y, input logic [7:0] exp,
                           input string tag);
        wait_ds(DS_INPUT, 20, {tag, " wait X"});
        pulse_enter(x);
        wait_ds(DS_INPUT, 20, {tag, " wait Y"});
        pulse_enter(y);
        wait_ds(DS_HALT, 6000, {tag, " wait halt"});
        chk({tag, " out"}, int'(out_data), int'(exp));
        chk({tag, " halt"}, int'(halt), 1);
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        reset   = 1'b0;
        init    = 1'b0;
        enter   = 1'b0;
        in_data = '0;

        tbl[0] = '{x: 8'd12,  y: 8'd18,  exp: 8'd6};
        tbl[1] = '{x: 8'd7,   y: 8'd7,   exp: 8'd7};
        tbl[2] = '{x: 8'd1,   y: 8'd127, exp: 8'd1};
        tbl[3] = '{x: 8'd127, y: 8'd1,   exp: 8'd1};
        tbl[4] = '{x: 8'd9,   y: 8'd6,   exp: 8'd3};
        tbl[5] = '{x: 8'd100, y: 8'd75,  exp: 8'd25};
        tbl[6] = '{x: 8'd64,  y: 8'd48,  exp: 8'd16};
        tbl[7] = '{x: 8'd127, y: 8'd126, exp: 8'd1};

        // Load program while held in reset
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        chk("reset out", int'(out_data), 0);
        chk("reset halt", int'(halt), 0);
        chk("reset state", int'(display_state), int'(DS_START));
        reset = 1'b1;

        // Fixed-timing run: X accepted at edge 4, Y at edge 11
        repeat (3) @(negedge clk);
        chk("first INPUT by cycle 3", int'(display_state), int'(DS_INPUT));
        pulse_enter(8'd12);
        repeat (6) @(negedge clk);
        chk("second INPUT by +6", int'(display_state), int'(DS_INPUT));
        pulse_enter(8'd18);
        wait_ds(DS_HALT, 6000, "timed wait halt");
        chk("timed out", int'(out_data), 6);
        chk("timed halt", int'(halt), 1);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            do_reset();
            run_gcd(tbl[i].x, tbl[i].y, tbl[i].exp, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d state", i), int'(display_state), int'(DS_HALT));
        end

        // Mid-run reset discards progress
        do_reset();
        wait_ds(DS_INPUT, 20, "midrst wait X");
        pulse_enter(8'd100);
        wait_ds(DS_INPUT, 20, "midrst wait Y");
        pulse_enter(8'd75);
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst out", int'(out_data), 0);
        chk("midrst halt", int'(halt), 0);
        chk("midrst state", int'(display_state), int'(DS_START));
        @(negedge clk);
        reset = 1'b1;
        run_gcd(8'd9, 8'd6, 8'd3, "rerun");

        // enter held high for 10 cycles with in=20
        do_reset();
        wait_ds(DS_INPUT, 20, "held wait X");
        in_data = 8'd20;
        enter   = 1'b1;
        repeat (10) @(negedge clk);
        enter   = 1'b0;
`ifdef PROC_ENTER_EDGE_EN
        @(negedge clk);
        chk("held second INPUT waits", int'(display_state), int'(DS_INPUT));
        pulse_enter(8'd5);
        wait_ds(DS_HALT, 6000, "held wait halt");
        chk("held out", int'(out_data), ref_gcd(20, 5));
`else
        wait_ds(DS_HALT, 6000, "held wait halt");
        chk("held out", int'(out_data), 20);
`endif

        // Random operands against the reference model; init under reset first
        reset = 1'b0;
        init  = 1'b1;
        @(negedge clk);
        init  = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [7:0] x;
            logic [7:0] y;
            x = 8'($urandom_range(127, 1));
            y = 8'($urandom_range(127, 1));
            if (i > 0) do_reset();
            run_gcd(x, y, 8'(ref_gcd(int'(x), int'(y))), $sformatf("rnd%0d x=%0d y=%0d", i, x, y));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
